reg_wb_arbiter: RTL and testbench

Write-back arbiter for the 32×32 register file's single write port. Up to NREQ write-back sources share the port, and each source uses a valid/ready handshake. Grants are round-robin, and the winning write is registered onto the register file's address, data and write-enable inputs. Writes to register 0 are dropped, and committed writes are counted. An optional read-bypass path forwards the in-flight write to the two read ports.

---
 rtl/reg_wb_arbiter_if.sv | 25 ++
 rtl/reg_wb_arbiter.sv | 113 +++++++++++
 tb/tb_reg_wb_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_arbiter_if.sv
// rtl/reg_wb_arbiter_if.sv - write-back request bus between requesters and the arbiter
interface reg_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ*AW-1:0] req_addr_i;
  logic [NREQ*DW-1:0] req_data_i;
  logic [NREQ-1:0]    req_ready_o;

  modport master (
    output req_valid_i,
    output req_addr_i,
    output req_data_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_addr_i,
    input  req_data_i,
    output req_ready_o
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - round-robin register write-back arbiter; WB_BYPASS_EN adds read forwarding
module reg_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int CW   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_i,
  reg_wb_arbiter_if.slave        wb,
  output logic [AW-1:0]          RDaddr_o,
  output logic [DW-1:0]          RDdata_o,
  output logic                   RegWrite_o,
  output logic [CW-1:0]          wr_cnt_o,
  input  logic [AW-1:0]          RSaddr_i,
  input  logic [AW-1:0]          RTaddr_i,
  input  logic [DW-1:0]          RSraw_i,
  input  logic [DW-1:0]          RTraw_i,
  output logic [DW-1:0]          RSdata_o,
  output logic [DW-1:0]          RTdata_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win, scan;
  logic          found, xfer;
  logic [AW-1:0] sel_addr, addr_q, addr_d;
  logic [DW-1:0] sel_data, data_q, data_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Find the first valid requester walking upward from ptr, wrapping at NREQ
  always_comb begin
    win   = '0;
    found = 1'b0;
    scan  = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && wb.req_valid_i[scan]) begin
        found = 1'b1;
        win   = scan;
      end
      scan = (scan == LAST) ? '0 : scan + 1'b1;
    end
  end

  // Mux the winner's address and data onto the commit path
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == win) begin
        sel_addr = wb.req_addr_i[i*AW +: AW];
        sel_data = wb.req_data_i[i*DW +: DW];
      end
    end
  end

  // Grant is withheld while stalled and while reset is asserted
  assign xfer = found && !stall_i && rst_i;
  assign wb.req_ready_o = xfer ? (NREQ'(1) << win) : '0;

  // Next state: a transfer loads the write and moves ptr past the winner
  always_comb begin
    ptr_d  = ptr_q;
    addr_d = addr_q;
    data_d = data_q;
    we_d   = 1'b0;
    if (xfer) begin
      addr_d = sel_addr;
      data_d = sel_data;
      we_d   = (sel_addr != '0);
      ptr_d  = (win == LAST) ? '0 : win + 1'b1;
    end
    cnt_d = cnt_q + CW'(we_d);
  end

  // State registers, cleared asynchronously so an in-flight write is dropped at once
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q   <= we_d;
      cnt_q  <= cnt_d;
    end
  end

  assign RDaddr_o   = addr_q;
  assign RDdata_o   = data_q;
  assign RegWrite_o = we_q;
  assign wr_cnt_o   = cnt_q;

`ifdef WB_BYPASS_EN
  // Forward the committing write to a read of the same register in the same cycle
  assign RSdata_o = (we_q && (addr_q == RSaddr_i)) ? data_q : RSraw_i;
  assign RTdata_o = (we_q && (addr_q == RTaddr_i)) ? data_q : RTraw_i;
`else
  assign RSdata_o = RSraw_i;
  assign RTdata_o = RTraw_i;
  logic unused_rd_addr;
  assign unused_rd_addr = ^{RSaddr_i, RTaddr_i};
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - self-checking bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [4:0]  rsaddr = '0, rtaddr = '0;
  logic [31:0] rsraw = '0, rtraw = '0;
  logic [4:0]  rdaddr;
  logic [31:0] rddata, rsdata, rtdata;
  logic        regwrite;
  logic [15:0] wr_cnt;

  int n_chk = 0;
  int n_fail = 0;

  reg_wb_arbiter_if #(.NREQ(3), .AW(5), .DW(32)) wb ();

  reg_wb_arbiter #(.NREQ(3), .AW(5), .DW(32), .CW(16)) dut (
    .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .wb(wb.slave),
    .RDaddr_o(rdaddr), .RDdata_o(rddata), .RegWrite_o(regwrite), .wr_cnt_o(wr_cnt),
    .RSaddr_i(rsaddr), .RTaddr_i(rtaddr), .RSraw_i(rsraw), .RTraw_i(rtraw),
    .RSdata_o(rsdata), .RTdata_o(rtdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic        stall;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  exp_ready;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [15:0] exp_cnt;
  } vec_t;

  function automatic vec_t mk(logic [2:0] v, logic s, logic [14:0] a, logic [95:0] d,
                              logic [2:0] r, logic we, logic [4:0] ea, logic [31:0] ed,
                              logic [15:0] ec);
    vec_t t;
    t.valid = v; t.stall = s; t.addr = a; t.data = d;
    t.exp_ready = r; t.exp_we = we; t.exp_addr = ea; t.exp_data = ed; t.exp_cnt = ec;
    return t;
  endfunction

  // Reference: first valid requester scanning upward from p, none if stalled
  function automatic int pick(logic [2:0] v, logic st, int p);
    int idx;
    if (st) return -1;
    for (int o = 0; o < 3; o++) begin
      idx = (p + o) % 3;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // Reset held for two edges with all requesters valid; released just after a rising edge
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    stall = 1'b0;
    wb.req_valid_i = 3'b111;
    wb.req_addr_i  = {5'd3, 5'd2, 5'd1};
    wb.req_data_i  = {32'hC, 32'hB, 32'hA};
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(wb.req_ready_o), 64'd0);
    chk("rst_we", 64'(regwrite), 64'd0);
    chk("rst_cnt", 64'(wr_cnt), 64'd0);
    chk("rst_addr", 64'(rdaddr), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  vec_t vecs[15];
  localparam logic [14:0] A  = {5'd3, 5'd2, 5'd1};
  localparam logic [95:0] D  = {32'hC, 32'hB, 32'hA};
  localparam logic [14:0] AZ = {5'd3, 5'd0, 5'd1};
  localparam logic [95:0] DZ = {32'hC, 32'hDEAD, 32'hA};

  int          m_ptr, w, last_w;
  logic        m_we;
  logic [4:0]  m_addr, ra;
  logic [31:0] m_data, exp_rs, exp_rt;
  logic [15:0] m_cnt;
  logic [2:0]  cur_v, exp_ready;
  logic [14:0] cur_a;
  logic [95:0] cur_d;

  initial begin
    vecs[0]  = mk(3'b111, 0, A,  D,  3'b001, 0, 5'd0, 32'h0,    16'd0);
    vecs[1]  = mk(3'b111, 0, A,  D,  3'b010, 1, 5'd1, 32'hA,    16'd1);
    vecs[2]  = mk(3'b111, 0, A,  D,  3'b100, 1, 5'd2, 32'hB,    16'd2);
    vecs[3]  = mk(3'b111, 0, A,  D,  3'b001, 1, 5'd3, 32'hC,    16'd3);
    vecs[4]  = mk(3'b111, 0, A,  D,  3'b010, 1, 5'd1, 32'hA,    16'd4);
    vecs[5]  = mk(3'b111, 0, A,  D,  3'b100, 1, 5'd2, 32'hB,    16'd5);
    vecs[6]  = mk(3'b000, 0, A,  D,  3'b000, 1, 5'd3, 32'hC,    16'd6);
    vecs[7]  = mk(3'b000, 0, A,  D,  3'b000, 0, 5'd3, 32'hC,    16'd6);
    vecs[8]  = mk(3'b010, 0, AZ, DZ, 3'b010, 0, 5'd3, 32'hC,    16'd6);
    vecs[9]  = mk(3'b000, 0, AZ, DZ, 3'b000, 0, 5'd0, 32'hDEAD, 16'd6);
    vecs[10] = mk(3'b111, 0, A,  D,  3'b100, 0, 5'd0, 32'hDEAD, 16'd6);
    vecs[11] = mk(3'b111, 1, A,  D,  3'b000, 1, 5'd3, 32'hC,    16'd7);
    vecs[12] = mk(3'b111, 1, A,  D,  3'b000, 0, 5'd3, 32'hC,    16'd7);
    vecs[13] = mk(3'b111, 0, A,  D,  3'b001, 0, 5'd3, 32'hC,    16'd7);
    vecs[14] = mk(3'b000, 0, A,  D,  3'b000, 1, 5'd1, 32'hA,    16'd8);

    wb.req_valid_i = '0;
    wb.req_addr_i  = '0;
    wb.req_data_i  = '0;

    // Directed table: fairness, register-0 drop, stall
    do_reset();
    for (int i = 0; i < 15; i++) begin
      wb.req_valid_i = vecs[i].valid;
      stall          = vecs[i].stall;
      wb.req_addr_i  = vecs[i].addr;
      wb.req_data_i  = vecs[i].data;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 64'(wb.req_ready_o), 64'(vecs[i].exp_ready));
      chk($sformatf("v%0d_we", i),    64'(regwrite),       64'(vecs[i].exp_we));
      chk($sformatf("v%0d_addr", i),  64'(rdaddr),         64'(vecs[i].exp_addr));
      chk($sformatf("v%0d_data", i),  64'(rddata),         64'(vecs[i].exp_data));
      chk($sformatf("v%0d_cnt", i),   64'(wr_cnt),         64'(vecs[i].exp_cnt));
      @(posedge clk); #1;
    end

    // Bypass then asynchronous reset while the write is committing
    do_reset();
    wb.req_valid_i = 3'b001;
    wb.req_addr_i  = {5'd0, 5'd0, 5'd5};
    wb.req_data_i  = {32'h0, 32'h0, 32'h1234};
    @(negedge clk);
    chk("byp_ready", 64'(wb.req_ready_o), 64'd1);
    @(posedge clk); #1;
    wb.req_valid_i = 3'b111;
    rsaddr = 5'd5; rsraw = 32'd5;
    rtaddr = 5'd6; rtraw = 32'h777;
    #1;
    chk("byp_we", 64'(regwrite), 64'd1);
    chk("byp_cnt", 64'(wr_cnt), 64'd1);
`ifdef WB_BYPASS_EN
    chk("byp_rs", 64'(rsdata), 64'h1234);
`else
    chk("byp_rs", 64'(rsdata), 64'd5);
`endif
    chk("byp_rt", 64'(rtdata), 64'h777);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_we", 64'(regwrite), 64'd0);
    chk("arst_cnt", 64'(wr_cnt), 64'd0);
    chk("arst_ready", 64'(wb.req_ready_o), 64'd0);
    chk("arst_rs", 64'(rsdata), 64'd5);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wb.req_valid_i = 3'b111;
    wb.req_addr_i  = {5'd3, 5'd2, 5'd1};
    @(negedge clk);
    chk("arst_first_grant", 64'(wb.req_ready_o), 64'd1);
    @(posedge clk); #1;

    // Randomized traffic against the reference model
    do_reset();
    m_ptr = 0; m_we = 0; m_addr = '0; m_data = '0; m_cnt = '0;
    last_w = -1;
    cur_v = '0; cur_a = '0; cur_d = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (cur_v[k] && k != last_w) begin
          if ($urandom_range(0, 9) == 0) cur_v[k] = 1'b0;
        end else begin
          cur_v[k] = ($urandom_range(0, 9) < 6);
          ra = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          cur_a[k*5 +: 5]   = ra;
          cur_d[k*32 +: 32] = $urandom;
        end
      end
      stall  = ($urandom_range(0, 4) == 0);
      rsaddr = $urandom_range(0, 1) ? m_addr : 5'($urandom_range(0, 31));
      rtaddr = $urandom_range(0, 1) ? m_addr : 5'($urandom_range(0, 31));
      rsraw  = $urandom;
      rtraw  = $urandom;
      wb.req_valid_i = cur_v;
      wb.req_addr_i  = cur_a;
      wb.req_data_i  = cur_d;

      w = pick(cur_v, stall, m_ptr);
      exp_ready = (w < 0) ? 3'b000 : 3'(1 << w);
`ifdef WB_BYPASS_EN
      exp_rs = (m_we && m_addr == rsaddr) ? m_data : rsraw;
      exp_rt = (m_we && m_addr == rtaddr) ? m_data : rtraw;
`else
      exp_rs = rsraw;
      exp_rt = rtraw;
`endif
      @(negedge clk);
      chk("rnd_ready", 64'(wb.req_ready_o), 64'(exp_ready));
      chk("rnd_we",    64'(regwrite),       64'(m_we));
      chk("rnd_addr",  64'(rdaddr),         64'(m_addr));
      chk("rnd_data",  64'(rddata),         64'(m_data));
      chk("rnd_cnt",   64'(wr_cnt),         64'(m_cnt));
      chk("rnd_rs",    64'(rsdata),         64'(exp_rs));
      chk("rnd_rt",    64'(rtdata),         64'(exp_rt));
      @(posedge clk); #1;
      if (w >= 0) begin
        m_addr = cur_a[w*5 +: 5];
        m_data = cur_d[w*32 +: 32];
        m_we   = (m_addr != 5'd0);
        m_ptr  = (w + 1) % 3;
        if (m_we) m_cnt = m_cnt + 16'd1;
      end else begin
        m_we = 1'b0;
      end
      last_w = w;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
